rvvi_ack_parser: RTL and testbench
==================================

RVVI_ACK_PARSER -- requirements
Module: rvvi_ack_parser

Interface
REQ-001 SHALL have parameter FRAME_COUNT_WIDTH, default 64, giving the width of the acknowledged frame counter, legal values 33..64.
REQ-002 SHALL have ports `clk  in  1` (sole clock) and `reset  in  1` (asynchronous, active-high).
REQ-003 SHALL have port `RvviAxiRdata  in  32`: receive AXI-stream data; frame byte k is on bits [8*(k%4)+7 : 8*(k%4)].
REQ-004 SHALL have port `RvviAxiRstrb  in  4`: byte keep.
REQ-005 SHALL have port `RvviAxiRlast  in  1`: last beat of frame.
REQ-006 SHALL have port `RvviAxiRvalid  in  1`: beat valid; there is no ready, so every valid beat is consumed.
REQ-007 SHALL have ports `DstMac  in  48`, `SrcMac  in  48`, `EthType  in  16` and `AckType  in  16`: expected header values, quasi-static.
REQ-008 SHALL have port `Valid  out  1`: one-cycle pulse marking an accepted acknowledge frame.
REQ-009 SHALL have port `FrameCount  out  FRAME_COUNT_WIDTH`: last accepted frame count.
REQ-010 SHALL have port `InterPacketDelay  out  32`: last accepted delay value.
REQ-011 SHALL have port `Error  out  1`: one-cycle pulse marking a rejected frame.
REQ-012 SHALL have ports `AcceptCount  out  16` and `RejectCount  out  16`: statistics outputs.

Function
REQ-013 SHALL send every multi-byte field most-significant byte first, at these byte offsets:
- DstMac: bytes 0-5
- SrcMac: bytes 6-11
- EthType: bytes 12-13
- AckType: bytes 14-15
- 64-bit frame count: bytes 16-23
- delay: bytes 24-27
- padding: byte 28 to Rlast
REQ-014 SHALL count valid beats with a 3-bit word index, 0..6, that saturates at 7 and clears to 0 on each Rlast beat.
REQ-015 SHALL use FSM states HDR, PAYLOAD, PAD and DROP, with reset state HDR.
REQ-016 In HDR (words 0-3), each beat SHALL be compared against the expected header bytes; any mismatch or Rstrb!=4'hF SHALL move the FSM to DROP.
REQ-017 Words 0-3 all matching SHALL move the FSM to PAYLOAD.
REQ-018 In PAYLOAD (words 4-6), beats SHALL be captured into shadow registers; Rstrb!=4'hF SHALL move the FSM to DROP.
REQ-019 Word 6 accepted without Rlast SHALL move the FSM to PAD.
REQ-020 In PAD, beats SHALL be ignored, including their Rstrb, until Rlast.
REQ-021 Rlast on word 6, or Rlast while in PAD, SHALL accept the frame.
REQ-022 Rlast on words 0-5 SHALL reject the frame as a runt.
REQ-023 In DROP, the FSM SHALL remain until Rlast and then reject the frame.
REQ-024 Every Rlast beat SHALL return the FSM to HDR in the following cycle.
REQ-025 On accept, the cycle after the Rlast beat SHALL see Valid=1 for exactly one cycle, with FrameCount = low FRAME_COUNT_WIDTH bits of the 64-bit field and InterPacketDelay updated in that same cycle.
REQ-026 On reject, the cycle after the Rlast beat SHALL see Error=1 for exactly one cycle, with FrameCount and InterPacketDelay unchanged.
REQ-027 Cycles with Rvalid=0 SHALL cause no state or index change; gaps within a frame are legal.
REQ-028 Valid and Error SHALL never both be 1 in the same cycle.
REQ-029 Back-to-back frames, where the next word 0 arrives in the cycle after Rlast, SHALL be parsed without loss.

Reset
REQ-030 While reset=1, the following SHALL hold asynchronously:
- FSM=HDR, word index=0
- Valid=0, Error=0
- FrameCount=0, InterPacketDelay=32'd2
- shadow registers=0
- AcceptCount=0, RejectCount=0
REQ-031 A frame in progress when reset asserts SHALL be abandoned with no Valid or Error pulse; its remaining beats after reset release SHALL be parsed as a new frame, which rejects unless the header matches.

Configuration
REQ-032 With macro RVVI_ACK_STATS_EN defined, AcceptCount and RejectCount SHALL increment in the same cycle as Valid and Error respectively, saturating at 16'hFFFF.
REQ-033 Without RVVI_ACK_STATS_EN, AcceptCount and RejectCount SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario, good frame: a 15-beat frame with matching header, frame count 64'h0000_0000_0000_0123 and delay 32'h10 -> the cycle after Rlast shows Valid=1, FrameCount=64'h123, InterPacketDelay=32'h10 and Error=0.
REQ-035 Scenario, header mismatch: the good frame with EthType=16'h005d -> Error pulses once, Valid stays 0, and FrameCount/InterPacketDelay keep their prior values.
REQ-036 Scenario, runt: a frame of 5 beats with Rlast on word 4 -> Error pulses; the next good frame with count 64'h7 yields Valid and FrameCount=7.
REQ-037 Scenario, gaps and back-to-back: two good frames with Rvalid toggling 1/0 on every beat and no idle cycle between the frames -> exactly two Valid pulses with the correct counts.
REQ-038 Scenario, reset mid-frame: reset asserted on word 2 and released, then the remaining beats arrive, then a good frame -> no pulse during reset, one Error for the remnant frame, one Valid for the good frame, and FrameCount=0 until that Valid.
REQ-039 Scenario, statistics: with RVVI_ACK_STATS_EN, 3 accepted and 2 rejected frames -> AcceptCount=3 and RejectCount=2; without the macro, both remain 0.

Source files
------------

// File: rtl/rvvi_ack_parser.sv
// rvvi_ack_parser
//   Parses RVVI acknowledge frames arriving on a 32-bit receive AXI stream
//   (no ready; every valid beat is consumed). Words 0-3 are checked against
//   the expected Ethernet header, words 4-6 carry the 64-bit frame count and
//   the 32-bit inter-packet delay (most-significant byte first), and anything
//   after word 6 is padding. One cycle after the Rlast beat, Valid pulses for
//   an accepted frame or Error pulses for a rejected one.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     RvviAxiRdata/Rstrb    beat data / byte keep (frame byte k on lane k%4)
//     RvviAxiRlast/Rvalid   last beat of frame / beat valid
//     DstMac, SrcMac,
//     EthType, AckType      expected header values (quasi-static)
//     Valid, Error          accept / reject pulses
//     FrameCount            low FRAME_COUNT_WIDTH bits of last accepted count
//     InterPacketDelay      last accepted delay (2 after reset)
//     AcceptCount,
//     RejectCount           saturating statistics
//
//   Configuration
//     RVVI_ACK_STATS_EN     when defined, AcceptCount/RejectCount count frames;
//                           otherwise they are tied to 0 and no counters exist.
module rvvi_ack_parser #(
  parameter int unsigned FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  RvviAxiRdata,
  input  logic [3:0]                   RvviAxiRstrb,
  input  logic                         RvviAxiRlast,
  input  logic                         RvviAxiRvalid,
  input  logic [47:0]                  DstMac,
  input  logic [47:0]                  SrcMac,
  input  logic [15:0]                  EthType,
  input  logic [15:0]                  AckType,
  output logic                         Valid,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic [31:0]                  InterPacketDelay,
  output logic                         Error,
  output logic [15:0]                  AcceptCount,
  output logic [15:0]                  RejectCount
);

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    PAD,
    DROP
  } state_e;

  // Lane k carries frame byte 4*w+k, so a big-endian field word is the
  // byte-reversed beat.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  widx_q, widx_d;
  logic [31:0] cnt_hi_q, cnt_hi_d;
  logic [31:0] cnt_lo_q, cnt_lo_d;
  logic [31:0] dly_q, dly_d;

  logic                         valid_q;
  logic                         error_q;
  logic [FRAME_COUNT_WIDTH-1:0] fcount_q;
  logic [31:0]                  ipd_q;

  logic [127:0] hdr;
  logic [31:0]  exp_word;
  logic [31:0]  beat_be;
  logic [63:0]  cnt64;
  logic         strb_ok;
  logic         accept;
  logic         reject;

  assign hdr     = {DstMac, SrcMac, EthType, AckType};
  assign beat_be = bswap(RvviAxiRdata);
  assign strb_ok = (RvviAxiRstrb == 4'hF);

  always_comb begin
    exp_word = '0;
    case (widx_q[1:0])
      2'd0: exp_word = bswap(hdr[127:96]);
      2'd1: exp_word = bswap(hdr[95:64]);
      2'd2: exp_word = bswap(hdr[63:32]);
      2'd3: exp_word = bswap(hdr[31:0]);
      default: exp_word = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    cnt_hi_d = cnt_hi_q;
    cnt_lo_d = cnt_lo_q;
    dly_d    = dly_q;
    accept   = 1'b0;
    reject   = 1'b0;

    if (RvviAxiRvalid) begin
      if (RvviAxiRlast) begin
        widx_d = '0;
      end else if (widx_q != 3'd7) begin
        widx_d = widx_q + 3'd1;
      end

      case (state_q)
        HDR: begin
          if (!strb_ok || (RvviAxiRdata != exp_word)) begin
            state_d = DROP;
          end else if (widx_q == 3'd3) begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!strb_ok) begin
            state_d = DROP;
          end else begin
            case (widx_q)
              3'd4:    cnt_hi_d = beat_be;
              3'd5:    cnt_lo_d = beat_be;
              default: dly_d    = beat_be;
            endcase
            if (widx_q == 3'd6) begin
              state_d = PAD;
            end
          end
        end
        PAD: begin
        end
        DROP: begin
        end
        default: state_d = DROP;
      endcase

      // Every Rlast ends the frame; anything short of a complete word 6
      // (runt, header/strobe failure) is a reject.
      if (RvviAxiRlast) begin
        state_d = HDR;
        accept  = (state_q == PAD) ||
                  ((state_q == PAYLOAD) && (widx_q == 3'd6) && strb_ok);
        reject  = !accept;
      end
    end
  end

  assign cnt64 = {cnt_hi_d, cnt_lo_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HDR;
      widx_q   <= '0;
      cnt_hi_q <= '0;
      cnt_lo_q <= '0;
      dly_q    <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      fcount_q <= '0;
      ipd_q    <= 32'd2;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_lo_q <= cnt_lo_d;
      dly_q    <= dly_d;
      valid_q  <= accept;
      error_q  <= reject;
      if (accept) begin
        fcount_q <= cnt64[FRAME_COUNT_WIDTH-1:0];
        ipd_q    <= dly_d;
      end
    end
  end

  assign Valid            = valid_q;
  assign Error            = error_q;
  assign FrameCount       = fcount_q;
  assign InterPacketDelay = ipd_q;

`ifdef RVVI_ACK_STATS_EN
  logic [15:0] acc_cnt_q;
  logic [15:0] rej_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      if (accept && (acc_cnt_q != '1)) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      if (reject && (rej_cnt_q != '1)) begin
        rej_cnt_q <= rej_cnt_q + 16'd1;
      end
    end
  end

  assign AcceptCount = acc_cnt_q;
  assign RejectCount = rej_cnt_q;
`else
  assign AcceptCount = '0;
  assign RejectCount = '0;
`endif

endmodule

// File: tb/tb_rvvi_ack_parser.sv
module tb_rvvi_ack_parser;

  localparam int unsigned FCW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     RvviAxiRdata;
  logic [3:0]      RvviAxiRstrb;
  logic            RvviAxiRlast;
  logic            RvviAxiRvalid;
  logic [47:0]     DstMac  = 48'h02_11_22_33_44_55;
  logic [47:0]     SrcMac  = 48'h02_aa_bb_cc_dd_ee;
  logic [15:0]     EthType = 16'h88b5;
  logic [15:0]     AckType = 16'h0a0c;
  logic            Valid;
  logic [FCW-1:0]  FrameCount;
  logic [31:0]     InterPacketDelay;
  logic            Error;
  logic [15:0]     AcceptCount;
  logic [15:0]     RejectCount;

  always #5 clk = ~clk;

  rvvi_ack_parser #(.FRAME_COUNT_WIDTH(FCW)) dut (
    .clk             (clk),
    .reset           (reset),
    .RvviAxiRdata    (RvviAxiRdata),
    .RvviAxiRstrb    (RvviAxiRstrb),
    .RvviAxiRlast    (RvviAxiRlast),
    .RvviAxiRvalid   (RvviAxiRvalid),
    .DstMac          (DstMac),
    .SrcMac          (SrcMac),
    .EthType         (EthType),
    .AckType         (AckType),
    .Valid           (Valid),
    .FrameCount      (FrameCount),
    .InterPacketDelay(InterPacketDelay),
    .Error           (Error),
    .AcceptCount     (AcceptCount),
    .RejectCount     (RejectCount)
  );

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          acc;
    logic [63:0] cnt;
    logic [31:0] dly;
  } result_t;

  result_t     exp_q[$];
  result_t     mon_r;
  logic [63:0] m_fc;
  logic [31:0] m_dly;
  int unsigned m_acc;
  int unsigned m_rej;

  logic [7:0] fb [0:63];
  logic [3:0] fs [0:15];
  int         nb;

  function automatic logic [7:0] hdr_byte(input int k);
    logic [127:0] h;
    h = {DstMac, SrcMac, EthType, AckType};
    return 8'(h >> (8 * (15 - k)));
  endfunction

  // Outcome of the frame whose first beat is beat 'off' of the buffer.
  function automatic result_t model(input int off);
    result_t r;
    r.acc = ((nb - off) >= 7);
    for (int w = 0; w < 7; w++)
      if (fs[off + w] != 4'hF) r.acc = 1'b0;
    for (int k = 0; k < 16; k++)
      if (fb[4 * off + k] != hdr_byte(k)) r.acc = 1'b0;
    r.cnt = '0;
    for (int k = 0; k < 8; k++) r.cnt = {r.cnt[55:0], fb[4 * off + 16 + k]};
    r.dly = '0;
    for (int k = 0; k < 4; k++) r.dly = {r.dly[23:0], fb[4 * off + 24 + k]};
    return r;
  endfunction

  task automatic build_good(input logic [63:0] cnt, input logic [31:0] dly, input int beats);
    nb = beats;
    for (int k = 0; k < 64; k++) fb[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) fb[k] = hdr_byte(k);
    for (int k = 0; k < 8; k++)  fb[16 + k] = 8'(cnt >> (8 * (7 - k)));
    for (int k = 0; k < 4; k++)  fb[24 + k] = 8'(dly >> (8 * (3 - k)));
    for (int w = 0; w < 16; w++) fs[w] = 4'hF;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0) begin
        mon_r = exp_q.pop_front();
        if (mon_r.acc) begin
          m_fc  = mon_r.cnt;
          m_dly = mon_r.dly;
          if (m_acc < 65535) m_acc++;
        end else if (m_rej < 65535) begin
          m_rej++;
        end
        check_eq("valid", Valid, mon_r.acc);
        check_eq("error", Error, !mon_r.acc);
        check_eq("framecount", FrameCount, m_fc);
        check_eq("delay", InterPacketDelay, m_dly);
`ifdef RVVI_ACK_STATS_EN
        check_eq("accept_count", AcceptCount, m_acc);
        check_eq("reject_count", RejectCount, m_rej);
`else
        check_eq("accept_count", AcceptCount, 0);
        check_eq("reject_count", RejectCount, 0);
`endif
      end else if (Valid || Error) begin
        check_eq("spurious_pulse", {Valid, Error}, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      RvviAxiRvalid = 1'b0;
      RvviAxiRdata  = $urandom;
      RvviAxiRstrb  = 4'($urandom);
      RvviAxiRlast  = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input int b);
    RvviAxiRdata  = {fb[4 * b + 3], fb[4 * b + 2], fb[4 * b + 1], fb[4 * b]};
    RvviAxiRstrb  = fs[b];
    RvviAxiRlast  = (b == nb - 1);
    RvviAxiRvalid = 1'b1;
  endtask

  // gap: 0 none, 1 one idle before every beat but the first, 2 random idles
  task automatic send_range(input int b0, input int b1, input int gap, input int off);
    for (int b = b0; b <= b1; b++) begin
      if (b > b0) begin
        if (gap == 1) idle(1);
        else if (gap == 2) idle($urandom_range(0, 2));
      end
      present(b);
      @(posedge clk);
      if (b == nb - 1) exp_q.push_back(model(off));
      #1;
    end
    RvviAxiRvalid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    send_range(0, nb - 1, gap, 0);
  endtask

  task automatic do_reset();
    RvviAxiRvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    m_fc  = '0;
    m_dly = 32'd2;
    m_acc = 0;
    m_rej = 0;
    check_eq("rst_valid", Valid, 0);
    check_eq("rst_error", Error, 0);
    check_eq("rst_framecount", FrameCount, 0);
    check_eq("rst_delay", InterPacketDelay, 32'd2);
    check_eq("rst_accept_count", AcceptCount, 0);
    check_eq("rst_reject_count", RejectCount, 0);
    reset = 1'b0;
  endtask

  initial begin
    RvviAxiRdata  = '0;
    RvviAxiRstrb  = '0;
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b0;
    reset         = 1'b0;
    #2;
    do_reset();
    idle(2);

    // good frame
    build_good(64'h0000_0000_0000_0123, 32'h10, 15);
    send_frame(0);
    idle(3);
    check_eq("good_framecount", FrameCount, 64'h123);
    check_eq("good_delay", InterPacketDelay, 32'h10);

    // header mismatch on EthType
    build_good(64'h0000_0000_0000_0456, 32'h20, 15);
    fb[12] = 8'h00;
    fb[13] = 8'h5d;
    send_frame(0);
    idle(3);
    check_eq("mismatch_framecount_kept", FrameCount, 64'h123);
    check_eq("mismatch_delay_kept", InterPacketDelay, 32'h10);

    // runt then good frame with count 7
    build_good(64'h0000_0000_0000_0999, 32'h30, 5);
    send_frame(0);
    build_good(64'h7, 32'h44, 8);
    send_frame(0);
    idle(3);
    check_eq("after_runt_framecount", FrameCount, 64'h7);

    // two back-to-back frames with Rvalid toggling; exactly 7 beats, then 9
    build_good(64'hdead_beef_0000_0001, 32'h55, 7);
    send_frame(1);
    build_good(64'hdead_beef_0000_0002, 32'h66, 9);
    send_frame(1);
    idle(3);
    check_eq("b2b_framecount", FrameCount, 64'hdead_beef_0000_0002);

    // reset in the middle of a frame; remnant then good frame
    build_good(64'h0123_4567_89ab_cdef, 32'h77, 12);
    send_range(0, 1, 0, 0);
    present(2);
    #2;
    do_reset();
    send_range(2, nb - 1, 0, 2);
    check_eq("remnant_framecount_zero", FrameCount, 0);
    build_good(64'h0000_0000_0000_0abc, 32'h88, 10);
    send_frame(0);
    idle(2);

    // statistics: 1 reject + 1 accept so far since reset; add 2 accepts, 1 reject
    build_good(64'h11, 32'h1, 7);
    send_frame(0);
    build_good(64'h22, 32'h2, 7);
    fs[5] = 4'h7;
    send_frame(0);
    build_good(64'h33, 32'h3, 11);
    fs[9] = 4'h1;
    send_frame(2);
    idle(3);
`ifdef RVVI_ACK_STATS_EN
    check_eq("stats_accept", AcceptCount, 3);
    check_eq("stats_reject", RejectCount, 2);
`else
    check_eq("stats_accept", AcceptCount, 0);
    check_eq("stats_reject", RejectCount, 0);
`endif

    // randomized frames
    for (int f = 0; f < 150; f++) begin
      int mode;
      mode = $urandom_range(0, 4);
      build_good({$urandom, $urandom}, $urandom, $urandom_range(7, 16));
      case (mode)
        1: fb[$urandom_range(0, 15)] ^= 8'(8'h01 << $urandom_range(0, 7));
        2: fs[$urandom_range(0, 6)] = 4'($urandom_range(0, 14));
        3: nb = $urandom_range(1, 6);
        4: if (nb > 7) fs[$urandom_range(7, nb - 1)] = 4'($urandom);
        default: ;
      endcase
      send_frame($urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end
    idle(3);
    check_eq("no_pending_results", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
